// File: rtl/execute_stage_if.sv
// Execute-stage bus: E_* fields in from the E pipeline register, e_* results
// out to the M register and the forwarding logic.
// The slave side is the execute stage and the master side is the producer/consumer.
interface execute_stage_if #(
   parameter int WORD_W = 64
);
   logic [3:0]        E_stat;
   logic [3:0]        E_icode;
   logic [3:0]        E_ifun;
   logic [WORD_W-1:0] E_valC;
   logic [WORD_W-1:0] E_valA;
   logic [WORD_W-1:0] E_valB;
   logic [3:0]        E_dstE;
   logic [3:0]        E_dstM;

   logic [3:0]        e_stat;
   logic [3:0]        e_icode;
   logic              e_Cnd;
   logic [WORD_W-1:0] e_valE;
   logic [WORD_W-1:0] e_valA;
   logic [3:0]        e_dstE;
   logic [3:0]        e_dstM;

   modport master (
      output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
      input  e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM
   );

   modport slave (
      input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
      output e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM
   );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 pipelined execute stage: ALU, ZF/SF/OF condition-code register,
// and branch/cmov condition evaluation. CC writes are suppressed whenever
// the E, M or W stage instruction carries a non-AOK status.
// Optional build macro EXEC_PERF_CNT_EN adds four saturating event counters.
module execute_stage #(
   parameter int WORD_W = 64,
   parameter int CNT_W  = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   execute_stage_if.slave      eif,
   input  logic [3:0]          m_stat,
   input  logic [3:0]          W_stat,
   output logic [2:0]          cc_out
`ifdef EXEC_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    cnt_ops,
   output logic [CNT_W-1:0]    cnt_ccupd,
   output logic [CNT_W-1:0]    cnt_jtaken,
   output logic [CNT_W-1:0]    cnt_bubble
`endif
);

   localparam logic [3:0] STAT_AOK = 4'b1000;

   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_RRMOVQ = 4'h2,
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_e;

   typedef enum logic [3:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_AND = 4'h2,
      ALU_XOR = 4'h3
   } alufun_e;

   logic [WORD_W-1:0] alu_a;
   logic [WORD_W-1:0] alu_b;
   logic [WORD_W-1:0] val_e;
   logic [3:0]        alufun;
   logic              new_zf;
   logic              new_sf;
   logic              new_of;
   logic              set_cc;
   logic              zf;
   logic              sf;
   logic              of;
   logic              cnd;

   // ALU operand selection keyed on instruction class
   always_comb begin
      alu_a = '0;
      alu_b = '0;
      unique case (eif.E_icode)
         I_RRMOVQ, I_OPQ:          alu_a = eif.E_valA;
         I_IRMOVQ, I_RMMOVQ,
         I_MRMOVQ:                 alu_a = eif.E_valC;
         I_CALL, I_PUSHQ:          alu_a = -WORD_W'(8);
         I_RET, I_POPQ:            alu_a = WORD_W'(8);
         default:                  alu_a = '0;
      endcase
      unique case (eif.E_icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
         I_RET, I_PUSHQ, I_POPQ:   alu_b = eif.E_valB;
         default:                  alu_b = '0;
      endcase
   end

   // ALU result and the flag values it would produce
   always_comb begin
      alufun = (eif.E_icode == I_OPQ) ? eif.E_ifun : ALU_ADD;
      val_e  = '0;
      new_of = 1'b0;
      unique case (alufun)
         ALU_ADD: begin
            val_e  = alu_b + alu_a;
            new_of = (alu_a[WORD_W-1] == alu_b[WORD_W-1]) &&
                     (val_e[WORD_W-1] != alu_a[WORD_W-1]);
         end
         ALU_SUB: begin
            val_e  = alu_b - alu_a;
            new_of = (alu_a[WORD_W-1] != alu_b[WORD_W-1]) &&
                     (val_e[WORD_W-1] != alu_b[WORD_W-1]);
         end
         ALU_AND: val_e = alu_b & alu_a;
         ALU_XOR: val_e = alu_b ^ alu_a;
         default: val_e = '0;
      endcase
      new_zf = (val_e == '0);
      new_sf = val_e[WORD_W-1];
   end

   assign set_cc = (eif.E_icode == I_OPQ) && (eif.E_ifun <= 4'd3) &&
                   (m_stat == STAT_AOK) && (W_stat == STAT_AOK) &&
                   (eif.E_stat == STAT_AOK);

   // Condition-code register; reset takes priority over an update
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zf <= 1'b1;
         sf <= 1'b0;
         of <= 1'b0;
      end else if (set_cc) begin
         zf <= new_zf;
         sf <= new_sf;
         of <= new_of;
      end
   end

   // Branch/cmov condition from the registered flags only
   always_comb begin
      cnd = 1'b0;
      unique case (eif.E_ifun)
         4'd0:    cnd = 1'b1;
         4'd1:    cnd = (sf ^ of) | zf;
         4'd2:    cnd = sf ^ of;
         4'd3:    cnd = zf;
         4'd4:    cnd = !zf;
         4'd5:    cnd = !(sf ^ of);
         4'd6:    cnd = !(sf ^ of) && !zf;
         default: cnd = 1'b0;
      endcase
   end

   assign cc_out      = {zf, sf, of};
   assign eif.e_stat  = eif.E_stat;
   assign eif.e_icode = eif.E_icode;
   assign eif.e_Cnd   = cnd;
   assign eif.e_valE  = val_e;
   assign eif.e_valA  = eif.E_valA;
   assign eif.e_dstE  = ((eif.E_icode == I_RRMOVQ) && !cnd) ? 4'hF : eif.E_dstE;
   assign eif.e_dstM  = eif.E_dstM;

`ifdef EXEC_PERF_CNT_EN
   // Saturating event counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_ops    <= '0;
         cnt_ccupd  <= '0;
         cnt_jtaken <= '0;
         cnt_bubble <= '0;
      end else begin
         if ((eif.E_icode == I_OPQ) && (eif.E_stat == STAT_AOK) && (cnt_ops != '1))
            cnt_ops <= cnt_ops + 1'b1;
         if (set_cc && (cnt_ccupd != '1))
            cnt_ccupd <= cnt_ccupd + 1'b1;
         if ((eif.E_icode == I_JXX) && cnd && (cnt_jtaken != '1))
            cnt_jtaken <= cnt_jtaken + 1'b1;
         if ((eif.E_icode == I_NOP) && (eif.E_stat == STAT_AOK) && (cnt_bubble != '1))
            cnt_bubble <= cnt_bubble + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with hand-computed expectations.
module tb_execute_stage;
   localparam int WORD_W = 64;
   localparam int CNT_W  = 32;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] m_stat;
   logic [3:0] W_stat;
   logic [2:0] cc_out;
   int         total = 0;
   int         bad = 0;

`ifdef EXEC_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_ops, cnt_ccupd, cnt_jtaken, cnt_bubble;
`endif

   execute_stage_if #(.WORD_W(WORD_W)) eif ();

   execute_stage #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .eif    (eif.slave),
      .m_stat (m_stat),
      .W_stat (W_stat),
      .cc_out (cc_out)
`ifdef EXEC_PERF_CNT_EN
      ,
      .cnt_ops    (cnt_ops),
      .cnt_ccupd  (cnt_ccupd),
      .cnt_jtaken (cnt_jtaken),
      .cnt_bubble (cnt_bubble)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [3:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                        input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                        input logic [3:0] dste);
      eif.E_stat  = stat;
      eif.E_icode = icode;
      eif.E_ifun  = ifun;
      eif.E_valA  = va;
      eif.E_valB  = vb;
      eif.E_valC  = vc;
      eif.E_dstE  = dste;
      eif.E_dstM  = 4'h5;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      m_stat = 4'b1000;
      W_stat = 4'b1000;
      drive(4'b1000, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
      repeat (2) tick();
      check("reset_cc", cc_out, 3'b100);
      check("bubble_valE", eif.e_valE, 0);
      check("bubble_cnd", eif.e_Cnd, 1);
      check("bubble_dstE", eif.e_dstE, 4'hF);
      rst_n = 1'b1;

      drive(4'b1000, 4'h7, 4'h3, 0, 0, 64'h40, 4'hF);
      check("je_after_reset", eif.e_Cnd, 1);
      drive(4'b1000, 4'h7, 4'h4, 0, 0, 64'h40, 4'hF);
      check("jne_after_reset", eif.e_Cnd, 0);
      drive(4'b1000, 4'h7, 4'h7, 0, 0, 64'h40, 4'hF);
      check("ifun7_cnd", eif.e_Cnd, 0);

      // 3 - 5
      drive(4'b1000, 4'h6, 4'h1, 64'd5, 64'd3, 0, 4'h2);
      check("sub_valE", eif.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
      check("opq_dstE", eif.e_dstE, 4'h2);
      check("pass_valA", eif.e_valA, 64'd5);
      check("pass_dstM", eif.e_dstM, 4'h5);
      check("cc_before_edge", cc_out, 3'b100);
      tick();
      check("sub_cc", cc_out, 3'b010);
      drive(4'b1000, 4'h7, 4'h2, 0, 0, 0, 4'hF);
      check("jl_after_sub", eif.e_Cnd, 1);
      drive(4'b1000, 4'h7, 4'h6, 0, 0, 0, 4'hF);
      check("jg_after_sub", eif.e_Cnd, 0);
      tick();

      drive(4'b1000, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h2);
      check("add_ovf_valE", eif.e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
      tick();
      check("add_ovf_cc", cc_out, 3'b011);
      drive(4'b1000, 4'h7, 4'h2, 0, 0, 0, 4'hF);
      check("jl_after_ovf", eif.e_Cnd, 0);
      drive(4'b1000, 4'h7, 4'h5, 0, 0, 0, 4'hF);
      check("jge_after_ovf", eif.e_Cnd, 1);

      drive(4'b1000, 4'h6, 4'h4, 64'd1, 64'd2, 0, 4'h2);
      check("bad_ifun_valE", eif.e_valE, 0);
      tick();
      check("bad_ifun_cc", cc_out, 3'b011);

      m_stat = 4'b0010;
      drive(4'b1000, 4'h6, 4'h3, 64'd9, 64'd9, 0, 4'h2);
      check("xor_adr_valE", eif.e_valE, 0);
      tick();
      check("m_adr_gate_cc", cc_out, 3'b011);
      m_stat = 4'b1000;
      W_stat = 4'b0100;
      tick();
      check("w_hlt_gate_cc", cc_out, 3'b011);
      W_stat = 4'b1000;
      drive(4'b0001, 4'h6, 4'h3, 64'd9, 64'd9, 0, 4'h2);
      tick();
      check("e_ins_gate_cc", cc_out, 3'b011);

      drive(4'b1000, 4'h6, 4'h3, 64'd9, 64'd9, 0, 4'h2);
      tick();
      check("xor_zero_cc", cc_out, 3'b100);

      drive(4'b1000, 4'h2, 4'h4, 64'h1234, 64'h77, 0, 4'h3);
      check("cmovne_cnd", eif.e_Cnd, 0);
      check("cmovne_dstE", eif.e_dstE, 4'hF);
      check("cmovne_valE", eif.e_valE, 64'h1234);
      drive(4'b1000, 4'h2, 4'h3, 64'h1234, 64'h77, 0, 4'h3);
      check("cmove_dstE", eif.e_dstE, 4'h3);
      check("cmove_cnd", eif.e_Cnd, 1);

      drive(4'b1000, 4'h3, 4'h0, 64'h99, 64'h55, 64'hABC, 4'h4);
      check("irmovq_valE", eif.e_valE, 64'hABC);
      drive(4'b1000, 4'h5, 4'h0, 64'h99, 64'h100, 64'h20, 4'hF);
      check("mrmovq_valE", eif.e_valE, 64'h120);

      // short reset so the counters start from zero before push/pop
      rst_n = 1'b0;
      drive(4'b1000, 4'h1, 4'h0, 0, 0, 0, 4'hF);
      tick();
      rst_n = 1'b1;
      drive(4'b1000, 4'hA, 4'h0, 64'h55, 64'h100, 0, 4'h4);
      check("pushq_valE", eif.e_valE, 64'hF8);
      tick();
      check("pushq_cc", cc_out, 3'b100);
      drive(4'b1000, 4'hB, 4'h0, 64'h55, 64'h100, 0, 4'h4);
      check("popq_valE", eif.e_valE, 64'h108);
      tick();
      check("popq_cc", cc_out, 3'b100);
      drive(4'b1000, 4'h1, 4'h0, 0, 0, 0, 4'hF);
      tick();
      tick();
      drive(4'b1000, 4'h8, 4'h0, 0, 64'h200, 64'h80, 4'h4);
      check("call_valE", eif.e_valE, 64'h1F8);
`ifdef EXEC_PERF_CNT_EN
      check("cnt_bubble", cnt_bubble, 2);
      check("cnt_ops", cnt_ops, 0);
      check("cnt_ccupd", cnt_ccupd, 0);
`endif

      drive(4'b1000, 4'h6, 4'h2, 64'hFF, 64'h0F, 0, 4'h2);
      check("and_valE", eif.e_valE, 64'h0F);
      tick();
      check("and_cc", cc_out, 3'b000);

      rst_n = 1'b0;
      drive(4'b1000, 4'h6, 4'h1, 64'd5, 64'd3, 0, 4'h2);
      tick();
      check("reset_beats_setcc", cc_out, 3'b100);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
